// File: rtl/plus_asic_io_regfile_if.sv
// CPU I/O bus between the Z80 bus mux and the ASIC register file.
interface plus_asic_io_regfile_if;
    logic [15:0] io_addr;
    logic [7:0]  io_din;
    logic        io_wr;
    logic        io_rd;
    logic [7:0]  io_dout;
    logic        io_dout_en;

    modport master (
        output io_addr, io_din, io_wr, io_rd,
        input  io_dout, io_dout_en
    );

    modport slave (
        input  io_addr, io_din, io_wr, io_rd,
        output io_dout, io_dout_en
    );
endinterface

// File: rtl/plus_asic_io_regfile.sv
// CPC+/GX4000 Gate Array / ASIC I/O register file: palette, RMR/RMR2/RAM config, CRTC file, unlock FSM.
// Optional CRTC readback on BFxx reads is enabled by defining PLUS_CRTC_READBACK_EN.
module plus_asic_io_regfile #(
    parameter int NUM_PENS  = 17,
    parameter int INK_W     = 5,
    parameter int CRTC_REGS = 18,
    parameter int SEQ_LEN   = 17
) (
    input  logic             clk_sys,
    input  logic             reset,
    plus_asic_io_regfile_if.slave bus,
    output logic [4:0]       pen_sel,
    input  logic [4:0]       pal_idx,
    output logic [INK_W-1:0] pal_ink,
    output logic [4:0]       rmr,
    output logic             int_ack,
    output logic [5:0]       ram_cfg,
    output logic [4:0]       rmr2,
    output logic             asic_unlocked,
    output logic [4:0]       crtc_sel,
    input  logic [4:0]       crtc_idx,
    output logic [7:0]       crtc_data
);
    localparam int          POS_W     = $clog2(SEQ_LEN);
    localparam logic [4:0]  BORDER    = 5'(NUM_PENS - 1);
    localparam logic [4:0]  CRTC_LAST = 5'(CRTC_REGS - 1);
    localparam logic [POS_W-1:0] LAST_POS = POS_W'(SEQ_LEN - 1);

    typedef enum logic {LOCKED, UNLOCKED} lock_t;

    function automatic logic [7:0] seq_byte(input logic [POS_W-1:0] p);
        case (int'(p))
            0:  seq_byte = 8'hFF;  1:  seq_byte = 8'h00;  2:  seq_byte = 8'hFF;
            3:  seq_byte = 8'h77;  4:  seq_byte = 8'hB3;  5:  seq_byte = 8'h51;
            6:  seq_byte = 8'hA8;  7:  seq_byte = 8'hD4;  8:  seq_byte = 8'h62;
            9:  seq_byte = 8'h39;  10: seq_byte = 8'h9C;  11: seq_byte = 8'h46;
            12: seq_byte = 8'h2B;  13: seq_byte = 8'h15;  14: seq_byte = 8'h8A;
            15: seq_byte = 8'hCD;  16: seq_byte = 8'hEE;
            default: seq_byte = 8'h00;
        endcase
    endfunction

    logic [INK_W-1:0] ink      [NUM_PENS];
    logic [7:0]       crtc_reg [CRTC_REGS];
    logic             wr_hold;
    lock_t            lock_state, lock_next;
    logic [POS_W-1:0] pos, pos_next;
    logic             unused_addr;

    assign unused_addr = ^bus.io_addr[7:0];

    logic ga_hit, sel_hit, dat_hit, wr_hit, wr_stb;
    assign ga_hit  = (bus.io_addr[15:14] == 2'b01);
    assign sel_hit = (bus.io_addr[15:8] == 8'hBC);
    assign dat_hit = (bus.io_addr[15:8] == 8'hBD);
    assign wr_hit  = ga_hit | sel_hit | dat_hit;
    // One strobe per access: the hold flag blocks repeats until io_wr drops
    assign wr_stb  = bus.io_wr && wr_hit && !wr_hold;

    logic [1:0] ga_cmd;
    logic       ga_wr, sel_wr, dat_wr, rmr2_wr, rmr_wr;
    assign ga_cmd  = bus.io_din[7:6];
    assign ga_wr   = wr_stb && ga_hit;
    assign sel_wr  = wr_stb && sel_hit;
    assign dat_wr  = wr_stb && dat_hit;
    assign rmr2_wr = ga_wr && (ga_cmd == 2'b10) && bus.io_din[5] && asic_unlocked;
    assign rmr_wr  = ga_wr && (ga_cmd == 2'b10) && !(bus.io_din[5] && asic_unlocked);

    assign pal_ink   = (pal_idx <= BORDER) ? ink[pal_idx] : '0;
    assign crtc_data = (crtc_idx <= CRTC_LAST) ? crtc_reg[crtc_idx] : 8'h00;
    assign asic_unlocked = (lock_state == UNLOCKED);

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            wr_hold <= 1'b0;
            pen_sel <= '0;
            rmr     <= '0;
            int_ack <= 1'b0;
            ram_cfg <= '0;
            rmr2    <= '0;
            crtc_sel <= '0;
            for (int i = 0; i < NUM_PENS; i++) ink[i] <= '0;
            for (int i = 0; i < CRTC_REGS; i++) crtc_reg[i] <= '0;
        end else begin
            wr_hold <= bus.io_wr && (wr_hold || wr_hit);
            int_ack <= rmr_wr && bus.io_din[4];
            if (ga_wr && ga_cmd == 2'b00)
                pen_sel <= bus.io_din[4] ? BORDER : {1'b0, bus.io_din[3:0]};
            if (ga_wr && ga_cmd == 2'b01 && pen_sel <= BORDER)
                ink[pen_sel] <= bus.io_din[INK_W-1:0];
            if (rmr2_wr) rmr2 <= bus.io_din[4:0];
            if (rmr_wr)  rmr  <= bus.io_din[4:0];
            if (ga_wr && ga_cmd == 2'b11) ram_cfg <= bus.io_din[5:0];
            if (sel_wr) crtc_sel <= bus.io_din[4:0];
            if (dat_wr && crtc_sel <= CRTC_LAST) crtc_reg[crtc_sel] <= bus.io_din;
        end
    end

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            lock_state <= LOCKED;
            pos        <= '0;
        end else begin
            lock_state <= lock_next;
            pos        <= pos_next;
        end
    end

    always_comb begin
        lock_next = lock_state;
        pos_next  = pos;
        if (sel_wr) begin
            if (pos == LAST_POS) begin
                lock_next = (bus.io_din == 8'hEE) ? UNLOCKED : LOCKED;
                pos_next  = '0;
            end else if (bus.io_din == seq_byte(pos)) begin
                pos_next = pos + 1'b1;
            end else begin
                // A stray FF is itself a valid first byte, so restart one step in
                pos_next = (bus.io_din == seq_byte('0)) ? POS_W'(1) : '0;
            end
        end
    end

    logic       rd_hit;
    logic [7:0] rd_data;
`ifdef PLUS_CRTC_READBACK_EN
    assign rd_hit  = (bus.io_addr[15:8] == 8'hBF) && asic_unlocked;
    assign rd_data = (crtc_sel <= CRTC_LAST) ? crtc_reg[crtc_sel] : 8'h00;
`else
    assign rd_hit  = 1'b0;
    assign rd_data = 8'hFF;
`endif

    always_ff @(posedge clk_sys) begin
        if (reset) begin
            bus.io_dout    <= 8'hFF;
            bus.io_dout_en <= 1'b0;
        end else if (bus.io_rd && !bus.io_wr && rd_hit) begin
            bus.io_dout    <= rd_data;
            bus.io_dout_en <= 1'b1;
        end else begin
            bus.io_dout    <= 8'hFF;
            bus.io_dout_en <= 1'b0;
        end
    end
endmodule

// File: tb/tb_plus_asic_io_regfile.sv
// Directed bench for plus_asic_io_regfile with a scoreboard of expected values.
module tb_plus_asic_io_regfile;
    logic       clk_sys = 1'b0;
    logic       reset;
    logic [4:0] pen_sel, pal_idx, rmr, rmr2, crtc_sel, crtc_idx;
    logic [4:0] pal_ink;
    logic [5:0] ram_cfg;
    logic       int_ack, asic_unlocked;
    logic [7:0] crtc_data;

    plus_asic_io_regfile_if bus();

    plus_asic_io_regfile dut (
        .clk_sys(clk_sys), .reset(reset), .bus(bus),
        .pen_sel(pen_sel), .pal_idx(pal_idx), .pal_ink(pal_ink),
        .rmr(rmr), .int_ack(int_ack), .ram_cfg(ram_cfg), .rmr2(rmr2),
        .asic_unlocked(asic_unlocked), .crtc_sel(crtc_sel),
        .crtc_idx(crtc_idx), .crtc_data(crtc_data)
    );

    always #5 clk_sys = ~clk_sys;

    int          n_tests = 0;
    int          n_fail  = 0;
    logic [31:0] exp_q[$];
    logic [7:0]  seq_tab [17];

    task automatic chk(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_tests++;
        if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL %s: observed %0h, no expected value queued", tag, obs);
            return;
        end
        exp = exp_q.pop_front();
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk_sys);
        reset = 1'b1;
        repeat (2) @(negedge clk_sys);
        reset = 1'b0;
    endtask

    task automatic io_out(input logic [15:0] a, input logic [7:0] d, input int hold, output int acks);
        acks = 0;
        @(negedge clk_sys);
        bus.io_addr = a; bus.io_din = d; bus.io_wr = 1'b1;
        for (int i = 0; i < hold; i++) begin
            @(negedge clk_sys);
            if (int_ack) acks++;
        end
        bus.io_wr = 1'b0;
        @(negedge clk_sys);
        if (int_ack) acks++;
    endtask

    task automatic out1(input logic [15:0] a, input logic [7:0] d);
        int acks;
        io_out(a, d, 1, acks);
    endtask

    task automatic bc_bytes(input int lo, input int hi);
        int acks;
        for (int i = lo; i <= hi; i++) io_out(16'hBC00, seq_tab[i], 3, acks);
    endtask

    task automatic io_in(input logic [15:0] a, output logic [7:0] d1, output logic e1,
                         output logic [7:0] d2, output logic e2);
        @(negedge clk_sys);
        bus.io_addr = a; bus.io_rd = 1'b1;
        @(negedge clk_sys);
        d1 = bus.io_dout; e1 = bus.io_dout_en;
        bus.io_rd = 1'b0;
        @(negedge clk_sys);
        d2 = bus.io_dout; e2 = bus.io_dout_en;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int acks;
        logic [7:0] d1, d2;
        logic e1, e2;
        seq_tab = '{8'hFF, 8'h00, 8'hFF, 8'h77, 8'hB3, 8'h51, 8'hA8, 8'hD4, 8'h62,
                    8'h39, 8'h9C, 8'h46, 8'h2B, 8'h15, 8'h8A, 8'hCD, 8'hEE};
        reset = 1'b0; pal_idx = '0; crtc_idx = '0;
        bus.io_addr = '0; bus.io_din = '0; bus.io_wr = 1'b0; bus.io_rd = 1'b0;

        do_reset();
        exp_q.push_back(0);     chk("rst_pen_sel", pen_sel);
        exp_q.push_back(0);     chk("rst_rmr", rmr);
        exp_q.push_back(0);     chk("rst_rmr2", rmr2);
        exp_q.push_back(0);     chk("rst_ram_cfg", ram_cfg);
        exp_q.push_back(0);     chk("rst_int_ack", int_ack);
        exp_q.push_back(0);     chk("rst_unlocked", asic_unlocked);
        exp_q.push_back(0);     chk("rst_crtc_sel", crtc_sel);
        exp_q.push_back(8'hFF); chk("rst_dout", bus.io_dout);
        exp_q.push_back(0);     chk("rst_dout_en", bus.io_dout_en);
        for (int i = 0; i < 32; i++) begin
            pal_idx = 5'(i); crtc_idx = 5'(i); #1;
            exp_q.push_back(0); chk($sformatf("rst_pal_ink[%0d]", i), pal_ink);
            exp_q.push_back(0); chk($sformatf("rst_crtc[%0d]", i), crtc_data);
        end

        io_out(16'h7F00, 8'h04, 4, acks);
        exp_q.push_back(4);     chk("pen_sel_4", pen_sel);
        io_out(16'h7F00, 8'h54, 4, acks);
        pal_idx = 5'd4; #1;
        exp_q.push_back(5'h14); chk("ink4", pal_ink);
        pal_idx = 5'd3; #1;
        exp_q.push_back(0);     chk("ink3_untouched", pal_ink);

        out1(16'h7F00, 8'h10);
        exp_q.push_back(16);    chk("pen_sel_border", pen_sel);
        out1(16'h7F00, 8'h4B);
        pal_idx = 5'd16; #1;
        exp_q.push_back(5'h0B); chk("ink_border", pal_ink);
        pal_idx = 5'd17; #1;
        exp_q.push_back(0);     chk("ink_out_of_range", pal_ink);

        io_out(16'h7F00, 8'h9D, 4, acks);
        exp_q.push_back(5'h1D); chk("rmr_1d", rmr);
        exp_q.push_back(1);     chk("int_ack_pulses", acks);

        bc_bytes(0, 15);
        exp_q.push_back(0);     chk("locked_before_last", asic_unlocked);
        bc_bytes(16, 16);
        exp_q.push_back(1);     chk("unlocked", asic_unlocked);
        io_out(16'h7F00, 8'hA3, 2, acks);
        exp_q.push_back(3);     chk("rmr2_03", rmr2);
        exp_q.push_back(5'h1D); chk("rmr_kept", rmr);
        exp_q.push_back(0);     chk("rmr2_no_int_ack", acks);

        bc_bytes(0, 15);
        out1(16'hBC00, 8'h00);
        exp_q.push_back(0);     chk("relocked", asic_unlocked);
        io_out(16'h7F00, 8'hA3, 2, acks);
        exp_q.push_back(3);     chk("locked_a3_to_rmr", rmr);
        exp_q.push_back(3);     chk("locked_rmr2_kept", rmr2);
        out1(16'h7F00, 8'hC5);
        exp_q.push_back(5);     chk("ram_cfg_05", ram_cfg);

        bc_bytes(0, 2);
        bc_bytes(0, 16);
        exp_q.push_back(1);     chk("restart_unlock", asic_unlocked);

        bc_bytes(0, 8);
        do_reset();
        exp_q.push_back(0);     chk("reset_midseq", asic_unlocked);
        bc_bytes(9, 16);
        exp_q.push_back(0);     chk("tail_stays_locked", asic_unlocked);

        out1(16'hBC00, 8'h0C);
        out1(16'hBD00, 8'h30);
        crtc_idx = 5'd12; #1;
        exp_q.push_back(8'h30); chk("crtc12", crtc_data);
        out1(16'hBC00, 8'h1F);
        exp_q.push_back(5'h1F); chk("crtc_sel_1f", crtc_sel);
        out1(16'hBD00, 8'h55);
        for (int i = 0; i < 32; i++) begin
            crtc_idx = 5'(i); #1;
            exp_q.push_back(i == 12 ? 8'h30 : 8'h00);
            chk($sformatf("crtc_after_drop[%0d]", i), crtc_data);
        end

        io_in(16'h7F00, d1, e1, d2, e2);
        exp_q.push_back(8'hFF); chk("ga_read_dout", d1);
        exp_q.push_back(0);     chk("ga_read_en", e1);
        io_in(16'hBF00, d1, e1, d2, e2);
        exp_q.push_back(0);     chk("bf_locked_en", e1);

        @(negedge clk_sys);
        bus.io_addr = 16'h7F00; bus.io_din = 8'hC3; bus.io_wr = 1'b1; bus.io_rd = 1'b1;
        @(negedge clk_sys);
        exp_q.push_back(0);     chk("wr_rd_en", bus.io_dout_en);
        bus.io_wr = 1'b0; bus.io_rd = 1'b0;
        @(negedge clk_sys);
        exp_q.push_back(3);     chk("wr_rd_ram_cfg", ram_cfg);

        bc_bytes(0, 16);
        out1(16'hBC00, 8'h0C);
        exp_q.push_back(1);     chk("unlocked_for_read", asic_unlocked);
        io_in(16'hBF00, d1, e1, d2, e2);
`ifdef PLUS_CRTC_READBACK_EN
        exp_q.push_back(8'h30); chk("bf_read_dout", d1);
        exp_q.push_back(1);     chk("bf_read_en", e1);
`else
        exp_q.push_back(8'hFF); chk("bf_read_dout", d1);
        exp_q.push_back(0);     chk("bf_read_en", e1);
`endif
        exp_q.push_back(8'hFF); chk("bf_read_idle_dout", d2);
        exp_q.push_back(0);     chk("bf_read_idle_en", e2);
        out1(16'hBC00, 8'h1F);
        io_in(16'hBF00, d1, e1, d2, e2);
`ifdef PLUS_CRTC_READBACK_EN
        exp_q.push_back(8'h00); chk("bf_read_oor_dout", d1);
        exp_q.push_back(1);     chk("bf_read_oor_en", e1);
`else
        exp_q.push_back(0);     chk("bf_read_oor_en", e1);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
